// File: rtl/mux3_rr_arbiter.sv
// mux3_rr_arbiter
//   Round-robin arbiter that owns the select of a shared 3:1 mux. Grants one
//   requester at a time, limits each grant to MAX_HOLD cycles, and qualifies
//   the muxed data with a valid flag.
//
//   Optional feature macro: MUX3_ARB_STATS_EN
//     defined   -> per-requester saturating 8-bit grant counters
//     undefined -> grant_cnt0..2 tied to 8'h00
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   req[2:0]    in   request per requester (bit i <-> in{i})
//   in0..in2    in   requester data, WIDTH bits
//   grant[2:0]  out  registered one-hot grant (zero when idle)
//   sel[1:0]    out  registered mux select (0..2), holds last value when idle
//   valid       out  high while a grant is active
//   out         out  in[sel] when valid, else zero (combinational)
//   grant_cnt0..2 out per-requester grant counters
//
// State table
//   S_IDLE  | no grant; sel holds its last value
//   S_GRANT | requester sel owns the mux; hold counter running
module mux3_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [2:0]       grant,
  output logic [1:0]       sel,
  output logic             valid,
  output logic [WIDTH-1:0] out,
  output logic [7:0]       grant_cnt0,
  output logic [7:0]       grant_cnt1,
  output logic [7:0]       grant_cnt2
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t     r_state, w_state_nx;
  logic [1:0] r_ptr, w_ptr_nx;
  logic [3:0] r_hold, w_hold_nx;
  logic [1:0] r_sel, w_sel_nx;
  logic [2:0] r_grant, w_grant_nx;

  logic [1:0] w_ptr_arb;
  logic       w_req_g;
  logic       w_release;
  logic       w_found;
  logic [1:0] w_idx;
  logic       w_new;
  logic [WIDTH-1:0] w_out;

  function automatic logic [1:0] f_inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Returns {found, index} of the first set request scanning from p.
  function automatic logic [2:0] f_arb(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] o0, o1, o2;
    logic [2:0] res;
    case (p)
      2'd1:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd2:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    res = 3'b000;
    if (r[o0])      res = {1'b1, o0};
    else if (r[o1]) res = {1'b1, o1};
    else if (r[o2]) res = {1'b1, o2};
    return res;
  endfunction

  always_comb begin
    w_req_g = 1'b0;
    case (r_sel)
      2'd0:    w_req_g = req[0];
      2'd1:    w_req_g = req[1];
      default: w_req_g = req[2];
    endcase
  end

  // On a release edge the pointer has already moved past the holder, so the
  // same-cycle arbitration uses the advanced pointer.
  always_comb begin
    w_release = 1'b0;
    w_ptr_arb = r_ptr;
    if (r_state == S_GRANT) begin
      w_release = !w_req_g || (r_hold == HOLD_LAST);
      if (w_release) w_ptr_arb = f_inc3(r_sel);
    end
    {w_found, w_idx} = f_arb(req, w_ptr_arb);
  end

  always_comb begin
    w_state_nx = r_state;
    w_sel_nx   = r_sel;
    w_hold_nx  = r_hold;
    w_ptr_nx   = r_ptr;
    w_new      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nx = S_GRANT;
          w_sel_nx   = w_idx;
          w_hold_nx  = 4'd0;
          w_new      = 1'b1;
        end
      end
      default: begin
        if (!w_release) begin
          w_hold_nx = r_hold + 4'd1;
        end else begin
          w_ptr_nx = w_ptr_arb;
          if (w_found) begin
            w_sel_nx  = w_idx;
            w_hold_nx = 4'd0;
            w_new     = 1'b1;
          end else begin
            w_state_nx = S_IDLE;
            w_hold_nx  = 4'd0;
          end
        end
      end
    endcase
    w_grant_nx = (w_state_nx == S_GRANT) ? (3'b001 << w_sel_nx) : 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_hold  <= 4'd0;
      r_sel   <= 2'd0;
      r_grant <= 3'b000;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_hold  <= w_hold_nx;
      r_sel   <= w_sel_nx;
      r_grant <= w_grant_nx;
    end
  end

  always_comb begin
    w_out = '0;
    if (r_state == S_GRANT) begin
      case (r_sel)
        2'd0:    w_out = in0;
        2'd1:    w_out = in1;
        default: w_out = in2;
      endcase
    end
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign valid = (r_state == S_GRANT);
  assign out   = w_out;

`ifdef MUX3_ARB_STATS_EN
  logic [7:0] r_cnt [3];

  // Counts every new grant, including back-to-back re-grants; saturates at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) r_cnt[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_new && (w_sel_nx == 2'(i)) && (r_cnt[i] != 8'hFF))
          r_cnt[i] <= r_cnt[i] + 8'h01;
      end
    end
  end

  assign grant_cnt0 = r_cnt[0];
  assign grant_cnt1 = r_cnt[1];
  assign grant_cnt2 = r_cnt[2];
`else
  assign grant_cnt0 = 8'h00;
  assign grant_cnt1 = 8'h00;
  assign grant_cnt2 = 8'h00;
`endif

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
module tb_mux3_rr_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;
`ifdef MUX3_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [2:0]       req;
  logic [WIDTH-1:0] in0, in1, in2;
  logic [2:0]       grant;
  logic [1:0]       sel;
  logic             valid;
  logic [WIDTH-1:0] out;
  logic [7:0]       grant_cnt0, grant_cnt1, grant_cnt2;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the mux, for how many cycles, and who is next.
  int m_cur;      // -1 when idle
  int m_held;     // cycles the current grant has been visible so far
  int m_ptr;
  int m_sel;
  int m_cnt [3];

  mux3_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .in0(in0), .in1(in1), .in2(in2),
    .grant(grant), .sel(sel), .valid(valid), .out(out),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .grant_cnt2(grant_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = -1; m_held = 0; m_ptr = 0; m_sel = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endtask

  function automatic int model_pick(input logic [2:0] r);
    for (int k = 0; k < 3; k++)
      if (r[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    return -1;
  endfunction

  task automatic model_grant(input int w);
    m_cur = w; m_sel = w; m_held = 1;
    if (STATS && m_cnt[w] < 255) m_cnt[w]++;
  endtask

  task automatic model_edge(input logic [2:0] r);
    int w;
    if (m_cur < 0) begin
      w = model_pick(r);
      if (w >= 0) model_grant(w);
    end else if (r[m_cur] && m_held < MAX_HOLD) begin
      m_held++;
    end else begin
      m_ptr = (m_cur + 1) % 3;
      w = model_pick(r);
      if (w >= 0) model_grant(w);
      else m_cur = -1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [WIDTH-1:0] eo;
    eo = '0;
    if (m_cur >= 0) eo = (m_sel == 0) ? in0 : (m_sel == 1) ? in1 : in2;
    chk({tag, ".grant"}, 32'(grant), (m_cur < 0) ? 32'd0 : (32'd1 << m_cur));
    chk({tag, ".sel"},   32'(sel),   32'(m_sel));
    chk({tag, ".valid"}, 32'(valid), (m_cur >= 0) ? 32'd1 : 32'd0);
    chk({tag, ".out"},   32'(out),   32'(eo));
    chk({tag, ".onehot"}, 32'($onehot0(grant)), 32'd1);
    chk({tag, ".cnt"}, {8'h00, grant_cnt2, grant_cnt1, grant_cnt0},
        {8'h00, 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])});
  endtask

  task automatic step(input logic [2:0] r, input string tag);
    @(negedge clk);
    req = r;
    in0 = WIDTH'($urandom); in1 = WIDTH'($urandom); in2 = WIDTH'($urandom);
    @(posedge clk);
    model_edge(r);
    #2;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = 3'b000;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] r;
    int len;
    rst_n = 1'b0; req = 3'b000; in0 = '0; in1 = '0; in2 = '0;
    model_reset();
    #12 check_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester held: re-granted every MAX_HOLD cycles, never dropped.
    for (int i = 0; i < 10; i++) begin
      step(3'b001, "single");
      chk("single.grant_const", 32'(grant), 32'd1);
    end
    chk("single.cnt0", 32'(grant_cnt0), STATS ? 32'd3 : 32'd0);
    step(3'b000, "single_drop");

    // All requesting from reset: sel 0x4, 1x4, 2x4, 0x4.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(3'b111, "all");
      chk("all.sel_seq", 32'(sel), 32'((i / 4) % 3));
    end

    // Early drop of requester 1, then pointer has moved to 2.
    do_reset();
    step(3'b010, "drop");
    step(3'b010, "drop");
    step(3'b000, "drop_rel");
    chk("drop.grant_zero", 32'(grant), 32'd0);
    chk("drop.out_zero", 32'(out), 32'd0);
    step(3'b111, "drop_next");
    chk("drop.next_is_2", 32'(grant), 32'b100);

    // Simultaneous 1 and 2 from reset: 1 wins, 2 follows with no bubble.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(3'b110, "simul");
      chk("simul.grant_seq", 32'(grant), (i < 4) ? 32'b010 : 32'b100);
    end

    // Asynchronous reset in the middle of a grant.
    step(3'b001, "pre_async");
    @(posedge clk);
    model_edge(req);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async");
    chk("async.grant", 32'(grant), 32'd0);
    chk("async.valid", 32'(valid), 32'd0);
    #2 rst_n = 1'b1;
    step(3'b100, "post_async");
    chk("post_async.grant", 32'(grant), 32'b100);

    // Random request patterns, each held a few cycles.
    do_reset();
    for (int n = 0; n < 120; n++) begin
      r = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 2)] ^= 1'b1;
        step(r, "rand");
      end
    end

    // Counter saturation: requester 0 alone for well over 255 grants.
    do_reset();
    for (int i = 0; i < 1100; i++) step(3'b001, "sat");
    chk("sat.cnt0", 32'(grant_cnt0), STATS ? 32'd255 : 32'd0);
    chk("sat.cnt1", 32'(grant_cnt1), 32'd0);
    chk("sat.cnt2", 32'(grant_cnt2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
